// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the ROM arbiter: FSM state encoding, read owner
// encoding and the default bus widths.
package rom_arbiter_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

endpackage

// File: rtl/rom_arb_wait_cnt.sv
// Starvation counter for the debug port.
// Counts CPU grants issued while a debug request is waiting, saturating at
// MAX_WAIT; any debug grant clears it. at_max tells the arbiter that the
// debug port must win the next contested arbitration.
//   clk, rst     : clock, synchronous active-high reset
//   cpu_grant    : CPU read granted this cycle
//   dbg_grant    : debug read granted this cycle
//   dbg_pending  : dbg_req level at the grant edge
//   wait_cnt     : current count
//   at_max       : wait_cnt == MAX_WAIT
module rom_arb_wait_cnt #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_grant,
  input  logic             dbg_grant,
  input  logic             dbg_pending,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (dbg_grant) begin
      cnt_d = '0;
    end else if (cpu_grant && dbg_pending && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign wait_cnt = cnt_q;
  assign at_max   = (cnt_q == CNT_MAX);

endmodule

// File: rtl/rom_arbiter.sv
// Two-port read arbiter in front of a single synchronous ROM.
// One read is in flight at a time; each read takes 4 clocks. The CPU has
// priority unless the debug port has been passed over MAX_WAIT times.
//   clk, rst               : clock, synchronous active-high reset
//   cpu_req/addr/data/valid: CPU read port (valid is a one-cycle pulse)
//   dbg_req/addr/data/ack  : debug read port (ack is a one-cycle pulse)
//   rom_addr, rom_oen      : registered ROM address and active-low enable
//   rom_data               : ROM data, valid one clock after oen=0 sampled
//   busy                   : FSM not in IDLE
//
// state      | meaning
// IDLE       | sample requests, latch winner address, drive rom_oen=0
// ISSUE      | ROM samples oen=0 on exit edge; release rom_oen
// CAPTURE    | register rom_data into owner's port, raise valid/ack
// DONE       | valid/ack high for this cycle only; back to IDLE
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_valid,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_oen,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              rom_oen_q, rom_oen_d;
  logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
  logic              cpu_valid_q, cpu_valid_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic              cpu_grant, dbg_grant;
  logic [CNT_W-1:0]  wait_cnt;
  logic              wait_max;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rom_addr_d  = rom_addr_q;
    rom_oen_d   = 1'b1;
    cpu_data_d  = cpu_data_q;
    dbg_data_d  = dbg_data_q;
    cpu_valid_d = 1'b0;
    dbg_ack_d   = 1'b0;
    cpu_grant   = 1'b0;
    dbg_grant   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Debug wins when alone, or when it has been starved long enough.
        if (dbg_req && (!cpu_req || wait_max)) begin
          dbg_grant  = 1'b1;
          owner_d    = OWN_DBG;
          rom_addr_d = dbg_addr;
          rom_oen_d  = 1'b0;
          state_d    = ST_ISSUE;
        end else if (cpu_req) begin
          cpu_grant  = 1'b1;
          owner_d    = OWN_CPU;
          rom_addr_d = cpu_addr;
          rom_oen_d  = 1'b0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (owner_q == OWN_CPU) begin
          cpu_data_d  = rom_data;
          cpu_valid_d = 1'b1;
        end else begin
          dbg_data_d = rom_data;
          dbg_ack_d  = 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_CPU;
      rom_addr_q  <= '0;
      rom_oen_q   <= 1'b1;
      cpu_data_q  <= '0;
      dbg_data_q  <= '0;
      cpu_valid_q <= 1'b0;
      dbg_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rom_addr_q  <= rom_addr_d;
      rom_oen_q   <= rom_oen_d;
      cpu_data_q  <= cpu_data_d;
      dbg_data_q  <= dbg_data_d;
      cpu_valid_q <= cpu_valid_d;
      dbg_ack_q   <= dbg_ack_d;
    end
  end

  rom_arb_wait_cnt #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_wait_cnt (
    .clk         (clk),
    .rst         (rst),
    .cpu_grant   (cpu_grant),
    .dbg_grant   (dbg_grant),
    .dbg_pending (dbg_req),
    .wait_cnt    (wait_cnt),
    .at_max      (wait_max)
  );

  assign cpu_data  = cpu_data_q;
  assign cpu_valid = cpu_valid_q;
  assign dbg_data  = dbg_data_q;
  assign dbg_ack   = dbg_ack_q;
  assign rom_addr  = rom_addr_q;
  assign rom_oen   = rom_oen_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed scenarios plus randomized traffic, with a
// transaction-timing reference model (grant edge g: oen low after g, valid
// after g+2, next arbitration at g+4) checked on every falling edge.
module tb_rom_arbiter;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 8;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_valid;
  logic              dbg_req = 1'b0;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_ack;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_oen;
  logic [DATA_W-1:0] rom_data = '0;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  rom_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_valid (cpu_valid),
    .dbg_req   (dbg_req),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_ack   (dbg_ack),
    .rom_addr  (rom_addr),
    .rom_oen   (rom_oen),
    .rom_data  (rom_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data = addr[7:0] ^ 8'hA5, one clock after oen=0 sampled.
  always @(posedge clk) begin
    if (!rom_oen) rom_data <= rom_addr[7:0] ^ 8'hA5;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int                n_edge  = 0;
  int                m_grant = -1000;
  bit                m_dbg_owner = 1'b0;
  logic [DATA_W-1:0] m_val = '0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_cpu_data = '0;
  logic [DATA_W-1:0] m_dbg_data = '0;
  int                m_starve = 0;

  always @(posedge clk) begin
    n_edge++;
    if (rst) begin
      m_grant    = -1000;
      m_addr     = '0;
      m_cpu_data = '0;
      m_dbg_data = '0;
      m_starve   = 0;
    end else begin
      if (n_edge == m_grant + 2) begin
        if (m_dbg_owner) m_dbg_data = m_val;
        else             m_cpu_data = m_val;
      end
      if (n_edge >= m_grant + 4 && (cpu_req || dbg_req)) begin
        m_grant = n_edge;
        if (dbg_req && (!cpu_req || m_starve == MAX_WAIT)) begin
          m_dbg_owner = 1'b1;
          m_addr      = dbg_addr;
          m_starve    = 0;
        end else begin
          m_dbg_owner = 1'b0;
          m_addr      = cpu_addr;
          if (dbg_req && m_starve < MAX_WAIT) m_starve = m_starve + 1;
        end
        m_val = m_addr[7:0] ^ 8'hA5;
      end
    end
  end

  logic prev_oen = 1'b1;

  always @(negedge clk) begin
    if (n_edge > 0) begin
      chk("rom_oen",   rom_oen,   (n_edge == m_grant) ? 0 : 1);
      chk("busy",      busy,      (n_edge >= m_grant && n_edge <= m_grant + 2) ? 1 : 0);
      chk("cpu_valid", cpu_valid, (n_edge == m_grant + 2 && !m_dbg_owner) ? 1 : 0);
      chk("dbg_ack",   dbg_ack,   (n_edge == m_grant + 2 && m_dbg_owner) ? 1 : 0);
      chk("rom_addr",  rom_addr,  m_addr);
      chk("cpu_data",  cpu_data,  m_cpu_data);
      chk("dbg_data",  dbg_data,  m_dbg_data);
      chk("wait_cnt",  dut.wait_cnt, m_starve);
      chk("oen_twice", (!prev_oen && !rom_oen) ? 1 : 0, 0);
      prev_oen = rom_oen;
    end
  end

  // sel: 0 cpu_valid, 1 dbg_ack, 2 rom_oen low. k = falling edges waited.
  task automatic wait_for(input int sel, input int maxc, output int k);
    bit hit;
    k = 0;
    hit = 1'b0;
    while (!hit && k < maxc) begin
      @(negedge clk);
      k++;
      case (sel)
        0:       hit = cpu_valid;
        1:       hit = dbg_ack;
        default: hit = !rom_oen;
      endcase
    end
    if (!hit) begin
      chk("timeout", 1, 0);
      k = -1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int k;
  int cnt;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_oen", rom_oen, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cpu_data", cpu_data, 0);

    // Basic CPU read at the top of the address space
    cpu_addr = 15'h7FFC;
    cpu_req  = 1'b1;
    wait_for(0, 10, k);
    chk("cpu_latency", k, 3);
    chk("cpu_data_7ffc", cpu_data, 8'h59);
    cpu_req = 1'b0;
    idle_cycles(2);

    // Simultaneous requests: CPU first, then debug
    cpu_addr = 15'h0010;
    dbg_addr = 15'h0020;
    cpu_req  = 1'b1;
    dbg_req  = 1'b1;
    wait_for(0, 10, k);
    chk("both_cpu_data", cpu_data, 8'hB5);
    chk("both_cpu_first", dbg_ack, 0);
    cpu_req = 1'b0;
    wait_for(1, 10, k);
    chk("both_dbg_gap", k, 4);
    chk("both_dbg_data", dbg_data, 8'h85);
    dbg_req = 1'b0;
    idle_cycles(2);

    // Starvation limit: 4 CPU reads, then debug, then CPU resumes
    cpu_addr = 15'h0100;
    dbg_addr = 15'h0201;
    cpu_req  = 1'b1;
    dbg_req  = 1'b1;
    cnt = 0;
    k = 0;
    while (!dbg_ack && k < 60) begin
      @(negedge clk);
      k++;
      if (cpu_valid) cnt++;
    end
    chk("starve_ack_seen", dbg_ack, 1);
    chk("starve_cpu_reads", cnt, 4);
    chk("starve_dbg_data", dbg_data, 8'hA4);
    dbg_req = 1'b0;
    wait_for(0, 10, k);
    chk("starve_cpu_resume", k, 4);
    chk("starve_cnt_clear", dut.wait_cnt, 0);
    cpu_req = 1'b0;
    idle_cycles(2);

    // Reset during CAPTURE aborts the read
    cpu_addr = 15'h0042;
    cpu_req  = 1'b1;
    wait_for(2, 10, k);
    @(negedge clk);
    rst     = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("abort_valid", cpu_valid, 0);
    chk("abort_oen", rom_oen, 1);
    chk("abort_addr", rom_addr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_data", cpu_data, 0);
    rst      = 1'b0;
    cpu_addr = 15'h0123;
    cpu_req  = 1'b1;
    wait_for(0, 10, k);
    chk("post_rst_latency", k, 3);
    chk("post_rst_data", cpu_data, 8'h86);
    cpu_req = 1'b0;
    idle_cycles(2);

    // Address change and req drop after grant
    cpu_addr = 15'h0055;
    cpu_req  = 1'b1;
    wait_for(2, 10, k);
    cpu_addr = 15'h0100;
    cpu_req  = 1'b0;
    wait_for(0, 10, k);
    chk("drop_latency", k, 2);
    chk("drop_data", cpu_data, 8'hF0);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (!rom_oen) cnt++;
    end
    chk("drop_no_second", cnt, 0);

    // req held through DONE: back-to-back reads
    cpu_addr = 15'h0033;
    cpu_req  = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (cpu_valid) cnt++;
    end
    chk("b2b_reads", cnt, 3);
    chk("b2b_data", cpu_data, 8'h96);
    cpu_req = 1'b0;
    idle_cycles(4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 79) == 0);
      cpu_req  = ($urandom_range(0, 2) != 0);
      dbg_req  = ($urandom_range(0, 2) != 0);
      cpu_addr = ADDR_W'($urandom);
      dbg_addr = ADDR_W'($urandom);
    end
    @(negedge clk);
    rst     = 1'b0;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    idle_cycles(6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
